// File: rtl/isq_issue_pipe.sv
// Two-entry issue pipe register (main + skid) between the issue queue and an
// execute unit, with robid-based rollback flush and an output handshake counter.
module isq_issue_pipe #(
  parameter int DATA_WIDTH   = 248,
  parameter int ROB_SIZE_LOG = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    flush_valid,
  input  logic [ROB_SIZE_LOG:0]   flush_robid,
  output logic [31:0]             issue_count
);

  localparam int RW = ROB_SIZE_LOG + 1;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both
  // high; valid never depends on ready, and in_ready depends on registered state only.

  logic                  main_valid_q, main_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [31:0]           issue_count_q, issue_count_d;

  logic [RW-1:0] main_robid, skid_robid, in_robid;
  logic          main_flush, skid_flush, in_flush;
  logic          in_fire, out_fire;
  logic          keep_main, keep_skid, keep_in;

  // Wrap bit flips the sense of the index comparison; equal robids are not younger.
  function automatic logic younger(input logic [RW-1:0] f, input logic [RW-1:0] r);
    return f[RW-1] ^ r[RW-1] ^ (f[RW-2:0] < r[RW-2:0]);
  endfunction

  assign main_robid = main_data_q[DATA_WIDTH-1 -: RW];
  assign skid_robid = skid_data_q[DATA_WIDTH-1 -: RW];
  assign in_robid   = in_data[DATA_WIDTH-1 -: RW];

  assign main_flush = flush_valid && younger(flush_robid, main_robid);
  assign skid_flush = flush_valid && younger(flush_robid, skid_robid);
  assign in_flush   = flush_valid && younger(flush_robid, in_robid);

  assign in_ready    = !skid_valid_q;
  assign out_valid   = main_valid_q && !main_flush;
  assign out_data    = main_data_q;
  assign issue_count = issue_count_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Survivors in age order: main, skid, incoming. At most two can exist
  // because in_fire is impossible while skid is occupied.
  assign keep_main = main_valid_q && !main_flush && !out_fire;
  assign keep_skid = skid_valid_q && !skid_flush;
  assign keep_in   = in_fire && !in_flush;

  always_comb begin
    main_valid_d  = 1'b0;
    main_data_d   = main_data_q;
    skid_valid_d  = 1'b0;
    skid_data_d   = skid_data_q;
    issue_count_d = issue_count_q + (out_fire ? 32'd1 : 32'd0);
    if (keep_main) begin
      main_valid_d = 1'b1;
      if (keep_skid) begin
        skid_valid_d = 1'b1;
      end else if (keep_in) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (keep_skid) begin
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      if (keep_in) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (keep_in) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      main_data_q   <= '0;
      skid_data_q   <= '0;
      issue_count_q <= '0;
    end else begin
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      main_data_q   <= main_data_d;
      skid_data_q   <= skid_data_d;
      issue_count_q <= issue_count_d;
    end
  end

endmodule

// File: tb/tb_isq_issue_pipe.sv
// Bench for isq_issue_pipe: directed scenarios plus random traffic, checked
// against a queue-based model of the held entries.
module tb_isq_issue_pipe;

  localparam int DW = 248;
  localparam int RW = 7;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush_valid;
  logic [RW-1:0] flush_robid;
  logic [31:0]   issue_count;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [31:0]   exp_count;
  bit            mon_en = 1'b0;

  always #5 clock = ~clock;

  isq_issue_pipe #(.DATA_WIDTH(DW), .ROB_SIZE_LOG(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush_valid (flush_valid),
    .flush_robid (flush_robid),
    .issue_count (issue_count)
  );

  function automatic bit is_younger(input logic [RW-1:0] f, input logic [DW-1:0] d);
    logic [RW-1:0] r;
    r = d[DW-1 -: RW];
    return f[6] ^ r[6] ^ (f[5:0] < r[5:0]);
  endfunction

  function automatic logic [DW-1:0] mk(input logic [RW-1:0] robid);
    logic [DW-1:0] d;
    logic [31:0]   w;
    for (int i = 0; i < 7; i++) d[i*32 +: 32] = $urandom;
    w = $urandom;
    d[DW-1:224] = w[23:0];
    d[DW-1 -: RW] = robid;
    return d;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model + monitor: compare at the falling edge, then advance the model
  // by the transfers the coming rising edge will perform.
  logic [DW-1:0] nq[$];
  always @(negedge clock) begin
    if (mon_en && reset_n) begin
      bit ev, acc;
      ev  = (exp_q.size() > 0) && !(flush_valid && is_younger(flush_robid, exp_q[0]));
      acc = in_valid && (exp_q.size() < 2);
      check("out_valid", DW'(out_valid), DW'(ev));
      check("in_ready", DW'(in_ready), DW'(exp_q.size() < 2));
      check("issue_count", DW'(issue_count), DW'(exp_count));
      if (ev) check("out_data", out_data, exp_q[0]);
      if (ev && out_ready) begin
        void'(exp_q.pop_front());
        exp_count++;
      end
      if (acc && !(flush_valid && is_younger(flush_robid, in_data))) exp_q.push_back(in_data);
      if (flush_valid) begin
        nq.delete();
        foreach (exp_q[i]) if (!is_younger(flush_robid, exp_q[i])) nq.push_back(exp_q[i]);
        exp_q = nq;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    flush_valid = 1'b0;
    flush_robid = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step(2);
    exp_q.delete();
    exp_count = '0;
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic push(input logic [RW-1:0] robid);
    in_valid = 1'b1;
    in_data  = mk(robid);
    step(1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    exp_count = '0;
    #3;
    check("reset out_valid", DW'(out_valid), DW'(0));
    check("reset in_ready", DW'(in_ready), DW'(1));
    check("reset issue_count", DW'(issue_count), DW'(0));
    mon_en = 1'b1;
    do_reset();

    // single issue, robid 0x05
    out_ready = 1'b1;
    push(7'h05);
    check("single out_valid", DW'(out_valid), DW'(1));
    check("single robid", DW'(out_data[DW-1 -: RW]), DW'(7'h05));
    step(1);
    check("single issue_count", DW'(issue_count), DW'(1));
    check("single drained", DW'(out_valid), DW'(0));

    // backpressure fills skid; third push stalls
    out_ready = 1'b0;
    push(7'h01);
    push(7'h02);
    check("full in_ready", DW'(in_ready), DW'(0));
    in_valid = 1'b1;
    in_data  = mk(7'h03);
    step(2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("order first", DW'(out_data[DW-1 -: RW]), DW'(7'h01));
    step(1);
    check("order second", DW'(out_data[DW-1 -: RW]), DW'(7'h02));
    step(2);

    // flush at main's robid drops skid only
    out_ready = 1'b0;
    push(7'h03);
    push(7'h04);
    flush_valid = 1'b1;
    flush_robid = 7'h03;
    #2;
    check("flush eq out_valid", DW'(out_valid), DW'(1));
    step(1);
    flush_valid = 1'b0;
    check("flush eq in_ready", DW'(in_ready), DW'(1));
    check("flush eq kept", DW'(out_data[DW-1 -: RW]), DW'(7'h03));
    out_ready = 1'b1;
    step(2);

    // wrap: 0x01 younger than 0x7E, 0x7D older
    out_ready = 1'b0;
    push(7'h01);
    flush_valid = 1'b1;
    flush_robid = 7'h7E;
    #2;
    check("wrap flushed out_valid", DW'(out_valid), DW'(0));
    step(1);
    flush_valid = 1'b0;
    check("wrap flushed empty", DW'(out_valid), DW'(0));
    push(7'h7D);
    flush_valid = 1'b1;
    step(1);
    flush_valid = 1'b0;
    check("wrap kept", DW'(out_valid), DW'(1));
    check("wrap kept robid", DW'(out_data[DW-1 -: RW]), DW'(7'h7D));
    out_ready = 1'b1;
    step(2);

    // simultaneous in/out fire with main only
    out_ready = 1'b0;
    push(7'h10);
    out_ready = 1'b1;
    push(7'h11);
    check("simul robid", DW'(out_data[DW-1 -: RW]), DW'(7'h11));
    check("simul in_ready", DW'(in_ready), DW'(1));
    step(2);

    // reset with both entries valid
    out_ready = 1'b0;
    push(7'h20);
    push(7'h21);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", DW'(out_valid), DW'(0));
    check("midreset in_ready", DW'(in_ready), DW'(1));
    check("midreset issue_count", DW'(issue_count), DW'(0));
    step(1);
    exp_q.delete();
    exp_count = '0;
    reset_n = 1'b1;
    step(1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = mk(7'($urandom_range(0, 127)));
      out_ready   = ($urandom_range(0, 2) != 0);
      flush_valid = ($urandom_range(0, 7) == 0);
      flush_robid = 7'($urandom_range(0, 127));
      step(1);
    end
    idle_inputs();
    out_ready = 1'b1;
    step(4);
    check("final empty", DW'(exp_q.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/isq_issue_pipe.md
ISQ_ISSUE_PIPE -- requirements
Module: isq_issue_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 248, issue payload width; payload robid field is bits [247:241] ({wrap, index[5:0]}).
REQ-002 SHALL have parameter ROB_SIZE_LOG, default 6, robid width is ROB_SIZE_LOG+1.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  issue-queue dequeue valid.
REQ-006 SHALL have port in_ready  output  1  this stage accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  issued instruction payload.
REQ-008 SHALL have port out_valid  output  1  payload valid toward execute unit.
REQ-009 SHALL have port out_ready  input  1  execute unit accepts out_data.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  payload toward execute unit.
REQ-011 SHALL have port flush_valid  input  1  rollback flush request.
REQ-012 SHALL have port flush_robid  input  ROB_SIZE_LOG+1  flush point robid.
REQ-013 SHALL have port issue_count  output  32  count of out handshakes.

Function
REQ-014 SHALL hold two entry registers, main and skid, each with valid bit; skid is always younger than main.
REQ-015 SHALL drive in_ready = !skid_valid (registered state only, no combinational path from out_ready).
REQ-016 SHALL drive out_data = main data; out_valid = main_valid && !(flush_valid && younger(main)).
REQ-017 SHALL define younger(e) = flush_robid[6] ^ e[247] ^ (flush_robid[5:0] < e[246:241]); equal robid is not younger.
REQ-018 SHALL treat in_fire = in_valid && in_ready, out_fire = out_valid && out_ready.
REQ-019 SHALL, on out_fire, load main from skid if skid_valid (skid cleared), else from in_data if in_fire, else clear main_valid.
REQ-020 SHALL, without out_fire, load in_data into main if main empty, else into skid, on in_fire.
REQ-021 SHALL give one-cycle latency: data accepted in cycle N appears on out_data in N+1 at earliest.
REQ-022 SHALL, when flush_valid, invalidate every held entry with younger()=1 and drop in_data with younger()=1 on the same edge; non-younger survivors compact so main holds the oldest.
REQ-023 SHALL, if main is flushed but skid survives (impossible in-order, but required), move skid to main.
REQ-024 SHALL increment issue_count by 1 per out_fire, wrapping 0xFFFFFFFF -> 0.
REQ-025 SHALL never lose, duplicate, or reorder accepted non-flushed entries.
REQ-026 SHALL tolerate in_valid dropping without handshake; no data held for unaccepted input.

Reset
REQ-027 SHALL, on reset_n low, asynchronously clear main_valid, skid_valid, issue_count; out_valid=0, in_ready=1, out_data undefined-don't-care (registers cleared to 0).
REQ-028 SHALL abandon any in-flight entries on reset mid-operation; first cycle after release behaves as empty.

Verification
REQ-029 SHALL cover: reset, in_valid=1 robid 0x05, out_ready=1 -> out_valid next cycle with robid 0x05, issue_count=1.
REQ-030 SHALL cover: out_ready=0, push robids 0x01,0x02 -> in_ready=0 after second accept; third push stalls; release out_ready -> 0x01,0x02 in order.
REQ-031 SHALL cover: main=0x03, skid=0x04, flush_valid robid 0x03 -> skid dropped, main kept, out_valid=1 for 0x03.
REQ-032 SHALL cover wrap: flush_robid 0x7E, held entry 0x01 (wrap bit 0) -> flushed; held 0x7D -> kept.
REQ-033 SHALL cover simultaneous in_fire, out_fire with main only -> main replaced, count+1, skid stays empty.
REQ-034 SHALL cover reset asserted with both entries valid -> out_valid=0, in_ready=1 immediately, issue_count=0.
